rr_arb_index: RTL and testbench
===============================

Name: rr_arb_index

Overview:
- Eight-requester round-robin arbiter that produces a registered 3-bit grant index plus a valid flag.
- Sits directly upstream of the team's 3-to-8 one-hot decoder: gnt_idx drives the decoder's select input, and the decoder output, qualified by gnt_valid, forms the one-hot grant bus.
- The grant is held until the owner signals completion, or until a watchdog timeout forces release.

Parameters:
- N_REQ, 8, number of requesters. Fixed at 8 to match the 3-to-8 decoder; other values are unsupported.
- IDX_W, 3, width of the grant index (log2 of N_REQ).
- TIMEOUT, 255, maximum number of cycles a grant may be held. Range 1 to 255. The hold counter is 8 bits wide.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset. Assertion is asynchronous. Release must be synchronous to clk (system responsibility).
- req  input  8  request vector; bit i is requester i. Level-sensitive.
- done  input  1  single-cycle pulse from the current owner releasing the grant.
- gnt_valid  output  1  registered; a grant is active.
- gnt_idx  output  3  registered index of the granted requester. Feeds the decoder.
- timeout_err  output  1  registered single-cycle pulse when a grant is force-released.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE, gnt_valid = 0, gnt_idx = 0, timeout_err = 0.
  - Priority pointer ptr = 0; hold counter = 0.
  - Reset asserted mid-grant drops gnt_valid immediately (asynchronously). No timeout_err is raised.
- State IDLE:
  - If req != 0, select the first set bit scanning ptr, ptr+1, ... with modulo-8 wrap. Example: ptr = 6 scans 6, 7, 0, 1, ..., 5.
  - On the next clk edge: gnt_idx = selection, gnt_valid = 1, state = GRANT, counter = 0.
  - Latency from req sampled to gnt_valid high is 1 cycle.
  - If req == 0, remain in IDLE with gnt_valid = 0.
  - done is ignored in IDLE.
- State GRANT:
  - gnt_idx and gnt_valid are held stable. The counter increments each cycle.
  - req is not re-sampled. Changes to req, including the owner dropping its own request, do not affect the grant.
  - done = 1: at the next edge gnt_valid = 0, ptr = gnt_idx + 1 (mod 8, so 7 wraps to 0), state = IDLE.
  - Counter reaches TIMEOUT with done = 0: at the next edge gnt_valid = 0, timeout_err = 1 for one cycle, ptr = gnt_idx + 1 (mod 8), state = IDLE.
  - done and timeout in the same cycle: done wins and no timeout_err is raised.
- Post-release bubble:
  - After a release there is exactly one cycle with gnt_valid = 0 before the next grant.
  - Minimum grant spacing is therefore 2 cycles. No back-to-back grants.
- gnt_idx retains the last granted value while gnt_valid = 0. Downstream must qualify the decoder output with gnt_valid.
- Fairness: a requester held high is granted within 7 other grants.
- No combinational path from any input to any output.

Decomposition:
- Shared package arb_pkg:
  - N_REQ, IDX_W and TIMEOUT_W localparams.
  - State enum type arb_state_t (IDLE, GRANT).
- One natural sub-module: rr_pick8. Purely combinational. Inputs req[7:0] and ptr[2:0]; outputs any and idx[2:0]. Implemented as a rotate, priority-encode, un-rotate.
- rr_arb_index itself holds the state register, ptr, counter and output registers.

Test Plan:
- Release reset with req = 8'h00 -> gnt_valid = 0, gnt_idx = 0, timeout_err = 0 for 10 cycles. Ignore a done pulse during this window.
- req = 8'h24 held, pulse done 3 cycles after each grant -> gnt_idx sequence 2, 5, 2, 5. Each grant asserts 1 cycle after IDLE. One bubble cycle between grants.
- Wrap: reach ptr = 6 (grant index 5 then release), then req = 8'h81 -> next gnt_idx = 7, then 0, then 7.
- Timeout with TIMEOUT = 4: req = 8'h08, no done -> gnt_idx = 3 valid for 5 cycles, then gnt_valid = 0 and a one-cycle timeout_err. Next grant of index 3 follows after the bubble.
- done asserted in the same cycle the counter equals TIMEOUT -> normal release with timeout_err = 0. Owner dropping req mid-grant -> grant held until done.
- Assert rst_n low mid-grant (gnt_idx = 4) -> gnt_valid = 0 immediately without a clock edge. After release with req = 8'h10 -> gnt_idx = 4 (ptr restarted at 0).

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and state type for the round-robin grant index arbiter
// Contents:
//   N_REQ     number of requesters (fixed at 8, matches the downstream 3-to-8 decoder)
//   IDX_W     width of the grant index
//   TIMEOUT_W width of the grant hold counter
//   arb_state_t  arbiter state (IDLE, GRANT)
package arb_pkg;

  localparam int N_REQ     = 8;
  localparam int IDX_W     = 3;
  localparam int TIMEOUT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational round-robin pick of the first set request at or after ptr
// Ports:
//   req  in  [7:0]  request vector
//   ptr  in  [2:0]  highest-priority position for this scan
//   any  out        at least one request is set
//   idx  out [2:0]  selected requester index (valid when any = 1)
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;

  // Rotate right so that requester ptr lands on bit 0; the lowest set bit of
  // rot is then the first requester in the modulo-8 scan ptr, ptr+1, ...
  assign rot = N_REQ'({req, req} >> ptr);

  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = IDX_W'(i);
      end
    end
  end

  assign any = |req;

  // Un-rotate: the 3-bit add wraps modulo 8.
  assign idx = ptr + off;

endmodule

// File: rtl/rr_arb_index.sv
// rtl/rr_arb_index.sv - eight-requester round-robin arbiter with registered grant index and watchdog
// Parameters:
//   TIMEOUT  maximum grant hold in cycles (1..255)
// Ports:
//   clk          in        rising-edge clock
//   rst_n        in        asynchronous active-low reset
//   req          in  [7:0] level-sensitive request vector
//   done         in        one-cycle release pulse from the current owner
//   gnt_valid    out       registered, a grant is active
//   gnt_idx      out [2:0] registered index of the granted requester
//   timeout_err  out       registered one-cycle pulse on a forced release
module rr_arb_index
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             timeout_err
);

  arb_state_t           state;
  logic [IDX_W-1:0]     ptr;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 pick_any;
  logic [IDX_W-1:0]     pick_idx;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt_valid   <= 1'b0;
      gnt_idx     <= '0;
      timeout_err <= 1'b0;
      ptr         <= '0;
      cnt         <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          // done is ignored here; req is the only thing that matters.
          if (pick_any) begin
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            cnt       <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          // req is not re-sampled while a grant is held. done takes
          // precedence over the watchdog when both happen together.
          if (done) begin
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + IDX_W'(1);
            state     <= IDLE;
          end else if (cnt == TIMEOUT_W'(TIMEOUT)) begin
            gnt_valid   <= 1'b0;
            timeout_err <= 1'b1;
            ptr         <= gnt_idx + IDX_W'(1);
            state       <= IDLE;
          end else begin
            cnt <= cnt + TIMEOUT_W'(1);
          end
        end
        default: begin
          gnt_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb_index.sv
// tb/tb_rr_arb_index.sv - scoreboard bench for rr_arb_index with a transaction-level reference model
module tb_rr_arb_index;

  localparam int TMO = 4;

  typedef struct {
    logic [2:0] idx;
    int         start;
    int         len;
    logic       to;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic       timeout_err;

  int   checks;
  int   errors;
  int   cyc;
  int   ptr_m;
  bit   mon_en;
  exp_t exp_q[$];

  rr_arb_index #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .gnt_valid   (gnt_valid),
    .gnt_idx     (gnt_idx),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: first requester met walking upward from the pointer, wrapping at 8.
  function automatic logic [2:0] model_pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return 3'((p + k) % 8);
    end
    return 3'd0;
  endfunction

  // Called at a falling edge while the arbiter is idle (or in its bubble).
  // hold = cycle within the grant where done is pulsed; hold > TMO means no done.
  // jmode: 0 keep req, 1 random req during grant, 2 req dropped during grant.
  task automatic do_txn(input logic [7:0] r, input int hold, input int jmode);
    exp_t e;
    bit   use_done;
    use_done = (hold <= TMO);
    req      = r;
    done     = 1'b0;
    e.idx    = model_pick(r, ptr_m);
    e.start  = cyc + 1;
    e.len    = use_done ? hold + 1 : TMO + 1;
    e.to     = !use_done;
    exp_q.push_back(e);
    ptr_m = (int'(e.idx) + 1) % 8;
    @(negedge clk);
    for (int k = 0; k < e.len; k++) begin
      if (jmode == 1) req = 8'($urandom);
      else if (jmode == 2) req = 8'h00;
      done = use_done && (k == hold);
      @(negedge clk);
    end
    done = 1'b0;
  endtask

  task automatic idle_gap(input int n, input bit pulse);
    req = 8'h00;
    for (int k = 0; k < n; k++) begin
      done = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    done = 1'b0;
  endtask

  // Monitor: pops an expectation at each grant start and checks index,
  // start cycle, stability, length and the timeout pulse.
  initial begin
    bit   prev;
    bit   have;
    int   run;
    exp_t cur;
    prev = 1'b0;
    have = 1'b0;
    run  = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev = 1'b0;
        have = 1'b0;
      end else begin
        if (gnt_valid === 1'b1 && !prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: got idx %0d expected no grant (cycle %0d)", gnt_idx, cyc);
            have = 1'b0;
          end else begin
            cur  = exp_q.pop_front();
            have = 1'b1;
            run  = 1;
            chk("grant_idx", 32'(gnt_idx), 32'(cur.idx));
            chk("grant_cycle", cyc, cur.start);
          end
        end else if (gnt_valid === 1'b1) begin
          run++;
          if (have) chk("idx_stable", 32'(gnt_idx), 32'(cur.idx));
        end
        if (gnt_valid !== 1'b1 && prev) begin
          if (have) begin
            chk("grant_len", run, cur.len);
            chk("timeout_err", 32'(timeout_err), 32'(cur.to));
            chk("idx_retained", 32'(gnt_idx), 32'(cur.idx));
          end
          have = 1'b0;
        end else begin
          chk("timeout_err_quiet", 32'(timeout_err), 0);
        end
        prev = (gnt_valid === 1'b1);
      end
    end
  end

  initial begin
    logic [7:0] r;
    int         h;
    checks = 0;
    errors = 0;
    ptr_m  = 0;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    req    = 8'h00;
    done   = 1'b0;

    @(negedge clk);
    chk("rst_valid", 32'(gnt_valid), 0);
    chk("rst_idx", 32'(gnt_idx), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Ten idle cycles after reset with a stray done pulse.
    for (int k = 0; k < 10; k++) begin
      done = (k == 4);
      @(negedge clk);
      chk("idle_valid", 32'(gnt_valid), 0);
      chk("idle_idx", 32'(gnt_idx), 0);
    end
    done = 1'b0;

    // Alternation between 2 and 5, done three cycles into each grant.
    for (int k = 0; k < 4; k++) do_txn(8'h24, 3, 0);
    // Wrap from pointer 6.
    for (int k = 0; k < 3; k++) do_txn(8'h81, 1, 0);
    // Watchdog release, then the same requester again after the bubble.
    do_txn(8'h08, TMO + 1, 0);
    do_txn(8'h08, TMO + 1, 0);
    // done in the very cycle the counter hits the limit.
    do_txn(8'h08, TMO, 0);
    // Owner drops its request mid-grant; grant held until done.
    do_txn(8'h08, 2, 2);
    do_txn(8'h01, 0, 0);
    do_txn(8'h80, 0, 1);

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 4), 1'b1);
      r = 8'($urandom) & 8'($urandom);
      if (r == 8'h00) r = 8'(1 << $urandom_range(0, 7));
      h = $urandom_range(0, TMO + 1);
      do_txn(r, h, $urandom_range(0, 2));
    end

    // Asynchronous reset in the middle of a grant of index 4.
    idle_gap(2, 1'b0);
    do_txn(8'h01, 0, 0);
    req = 8'h10;
    exp_q.push_back('{idx: 3'd4, start: cyc + 1, len: 0, to: 1'b0});
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_valid", 32'(gnt_valid), 1);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("async_rst_valid", 32'(gnt_valid), 0);
    chk("async_rst_terr", 32'(timeout_err), 0);
    chk("async_rst_idx", 32'(gnt_idx), 0);
    exp_q.delete();
    ptr_m = 0;
    req   = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("held_rst_valid", 32'(gnt_valid), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    do_txn(8'h11, 1, 0);
    do_txn(8'h10, 1, 0);
    idle_gap(4, 1'b0);

    chk("queue_drained", exp_q.size(), 0);
    chk("final_valid", 32'(gnt_valid), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
